// File: rtl/mips_chk_pkg.sv
// mips_chk_pkg
// Shared types for the MIPS trace checker: per-entry check modes, the
// checker FSM states, the table entry layout and a small mode helper.
// No ports; imported by mips_chk_table and mips_trace_checker.

package mips_chk_pkg;

  // Widest observation bus the table entry layout can carry. Narrower
  // checkers zero-extend their expected values into this field.
  localparam int CHK_VAL_W = 64;

  // What a table entry asks the checker to do when its PC is visited.
  // Codes 6 and 7 are reserved and behave like MODE_NONE.
  typedef enum logic [2:0] {
    MODE_NONE   = 3'd0,
    MODE_ALU    = 3'd1,
    MODE_NEXT   = 3'd2,
    MODE_ADDR   = 3'd3,
    MODE_STORE  = 3'd4,
    MODE_FORBID = 3'd5
  } chk_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  typedef struct packed {
    chk_mode_e              mode;
    logic [CHK_VAL_W-1:0]   value;
  } chk_entry_t;

  // True for the modes that actually check something; NONE and the
  // reserved codes make the visited PC count as unknown.
  function automatic logic isCheckedMode(input logic [2:0] mode);
    return (mode >= 3'd1) && (mode <= 3'd5);
  endfunction

endpackage

// File: rtl/mips_chk_table.sv
// mips_chk_table
// Expectation table: DEPTH entries of {mode, value}, one write port and a
// combinational read port. Reset returns every entry to MODE_NONE; the
// stored values are left alone because a NONE entry never looks at them.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-low reset
//   i_we         write strobe (already qualified by the caller)
//   i_wIdx       entry to write
//   i_wMode      3-bit mode code to store
//   i_wValue     expected value to store
//   i_rIdx       entry to read
//   o_entry      entry at i_rIdx, value zero-extended to CHK_VAL_W

module mips_chk_table
  import mips_chk_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_wIdx,
  input  logic [2:0]               i_wMode,
  input  logic [DATA_W-1:0]        i_wValue,
  input  logic [$clog2(DEPTH)-1:0] i_rIdx,
  output chk_entry_t               o_entry
);

  logic [2:0]        r_mode  [DEPTH];
  logic [DATA_W-1:0] r_value [DEPTH];

  // Mode storage doubles as the valid bit: clearing it to NONE on reset is
  // what invalidates the whole table in one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mode[i] <= MODE_NONE;
      end
    end else if (i_we) begin
      r_mode[i_wIdx] <= i_wMode;
    end
  end

  // Values need no reset; keeping them out of the reset path lets them map
  // onto plain distributed RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_value[i_wIdx] <= i_wValue;
    end
  end

  // Asynchronous read so the checker can judge the current PC in the same
  // cycle it is sampled.
  always_comb begin
    o_entry       = '0;
    o_entry.mode  = chk_mode_e'(r_mode[i_rIdx]);
    o_entry.value = CHK_VAL_W'(r_value[i_rIdx]);
  end

endmodule

// File: rtl/mips_trace_checker.sv
// mips_trace_checker
// Self-checking monitor for the single-cycle MIPS core. Every RUN cycle it
// looks up the current PC in the expectation table and checks ALU results,
// memory addresses, store data, forbidden PCs and (one cycle later) branch
// or jump targets. Produces saturating error/unknown counters, a record of
// the first failure and a done/pass verdict.
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   pc, aluout, readData,
//   writeData                     core observation bus
//   tbl_we, tbl_idx, tbl_mode,
//   tbl_value                     table write port, honoured in IDLE only
//   start, max_cycles             begin a run of max_cycles samples
//   fail_pulse                    one-cycle strobe per mismatching cycle
//   err_cnt, unk_cnt              saturating mismatch / unknown-PC counts
//   first_fail_pc, first_fail_val PC and observed value of first mismatch
//   done, pass                    verdict, pass = done && err_cnt == 0

module mips_trace_checker
  import mips_chk_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int CYC_W  = 16,
  parameter int ERR_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        pc,
  input  logic [DATA_W-1:0]        aluout,
  input  logic [DATA_W-1:0]        readData,
  input  logic [DATA_W-1:0]        writeData,
  input  logic                     tbl_we,
  input  logic [$clog2(DEPTH)-1:0] tbl_idx,
  input  logic [2:0]               tbl_mode,
  input  logic [DATA_W-1:0]        tbl_value,
  input  logic                     start,
  input  logic [CYC_W-1:0]         max_cycles,
  output logic                     fail_pulse,
  output logic [ERR_W-1:0]         err_cnt,
  output logic [ERR_W-1:0]         unk_cnt,
  output logic [DATA_W-1:0]        first_fail_pc,
  output logic [DATA_W-1:0]        first_fail_val,
  output logic                     done,
  output logic                     pass
);

  localparam int IDX_W = $clog2(DEPTH);

  chk_state_e        r_state;
  logic [CYC_W-1:0]  r_cycCnt;
  logic [CYC_W-1:0]  r_maxCycles;
  logic [ERR_W-1:0]  r_errCnt;
  logic [ERR_W-1:0]  r_unkCnt;
  logic [DATA_W-1:0] r_firstPc;
  logic [DATA_W-1:0] r_firstVal;
  logic              r_haveFirst;
  logic              r_pendValid;
  logic [DATA_W-1:0] r_pendPc;
  logic [DATA_W-1:0] r_pendExp;
  logic              r_failPulse;
  logic              r_done;
  logic              r_pass;

  chk_entry_t        w_entry;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_expVal;
  logic              w_known;
  logic              w_curMis;
  logic [DATA_W-1:0] w_curVal;
  logic              w_setPend;
  logic              w_pendMis;
  logic [ERR_W:0]    w_errSum;
  logic [ERR_W-1:0]  w_errNext;
  logic [ERR_W-1:0]  w_unkNext;
  logic              w_lastCycle;
  logic              w_tblWe;
  logic              w_unusedBits;

  assign w_idx    = pc[IDX_W+1:2];
  assign w_expVal = w_entry.value[DATA_W-1:0];
  assign w_tblWe  = tbl_we && (r_state == ST_IDLE);

  // readData is observed but no mode checks it; the upper entry bits are
  // only zero padding when DATA_W is narrower than the entry layout.
  assign w_unusedBits = ^readData ^ ^(w_entry.value >> DATA_W);

  mips_chk_table #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_tblWe),
    .i_wIdx   (tbl_idx),
    .i_wMode  (tbl_mode),
    .i_wValue (tbl_value),
    .i_rIdx   (w_idx),
    .o_entry  (w_entry)
  );

  // Judge the PC being sampled this cycle. Anything past the end of the
  // table, misaligned, or mapped to a NONE/reserved entry is "unknown" and
  // never produces a mismatch. A NEXT entry produces no verdict now; it
  // only arms the pending check for the following cycle.
  always_comb begin
    w_known   = 1'b0;
    w_curMis  = 1'b0;
    w_curVal  = '0;
    w_setPend = 1'b0;
    if (((pc >> (IDX_W + 2)) == '0) && (pc[1:0] == 2'b00) &&
        isCheckedMode(w_entry.mode)) begin
      w_known = 1'b1;
      case (w_entry.mode)
        MODE_ALU, MODE_ADDR: begin
          w_curMis = (aluout !== w_expVal);
          w_curVal = aluout;
        end
        MODE_STORE: begin
          w_curMis = (writeData !== w_expVal);
          w_curVal = writeData;
        end
        MODE_NEXT: begin
          w_setPend = 1'b1;
        end
        MODE_FORBID: begin
          w_curMis = 1'b1;
          w_curVal = pc;
        end
        default: begin
          w_known = 1'b0;
        end
      endcase
    end
  end

  // The pending NEXT check and the current-PC check are independent, so
  // the error counter can step by two in one cycle; a carry out of the top
  // bit means we crossed all-ones and must stick there.
  always_comb begin
    w_pendMis = r_pendValid && (pc !== r_pendExp);
    w_errSum  = {1'b0, r_errCnt} +
                {{(ERR_W-1){1'b0}}, w_curMis & w_pendMis, w_curMis ^ w_pendMis};
    w_errNext = w_errSum[ERR_W] ? '1 : w_errSum[ERR_W-1:0];
    w_unkNext = (&r_unkCnt) ? r_unkCnt : r_unkCnt + ERR_W'(1);
    w_lastCycle = (r_maxCycles == '0) || (r_cycCnt == r_maxCycles - CYC_W'(1));
  end

  // Checker FSM with all outputs registered. IDLE and DONE both accept
  // start, which wipes the previous verdict but keeps the table. In RUN
  // every edge is a sample; the sample that hits the cycle limit moves us to
  // DONE and any NEXT check it would have armed is discarded, since there
  // is no following PC to judge it against. When both checks fail in the
  // same cycle the older (pending) one owns the first-failure record.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cycCnt    <= '0;
      r_maxCycles <= '0;
      r_errCnt    <= '0;
      r_unkCnt    <= '0;
      r_firstPc   <= '0;
      r_firstVal  <= '0;
      r_haveFirst <= 1'b0;
      r_pendValid <= 1'b0;
      r_pendPc    <= '0;
      r_pendExp   <= '0;
      r_failPulse <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_failPulse <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_cycCnt    <= '0;
            r_maxCycles <= max_cycles;
            r_errCnt    <= '0;
            r_unkCnt    <= '0;
            r_firstPc   <= '0;
            r_firstVal  <= '0;
            r_haveFirst <= 1'b0;
            r_pendValid <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        ST_RUN: begin
          r_failPulse <= w_curMis | w_pendMis;
          r_errCnt    <= w_errNext;
          if (!w_known) begin
            r_unkCnt <= w_unkNext;
          end
          if ((w_curMis || w_pendMis) && (r_errCnt == '0) && !r_haveFirst) begin
            r_haveFirst <= 1'b1;
            if (w_pendMis) begin
              r_firstPc  <= r_pendPc;
              r_firstVal <= pc;
            end else begin
              r_firstPc  <= pc;
              r_firstVal <= w_curVal;
            end
          end
          if (w_lastCycle) begin
            r_state     <= ST_DONE;
            r_done      <= 1'b1;
            r_pass      <= (w_errNext == '0);
            r_pendValid <= 1'b0;
          end else begin
            r_cycCnt    <= r_cycCnt + CYC_W'(1);
            r_pendValid <= w_setPend;
            r_pendPc    <= pc;
            r_pendExp   <= w_expVal;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fail_pulse     = r_failPulse;
  assign err_cnt        = r_errCnt;
  assign unk_cnt        = r_unkCnt;
  assign first_fail_pc  = r_firstPc;
  assign first_fail_val = r_firstVal;
  assign done           = r_done;
  assign pass           = r_pass;

endmodule

// File: tb/tb_mips_trace_checker.sv
// tb_mips_trace_checker
// Directed bench for mips_trace_checker with default parameters
// (DATA_W=32, DEPTH=32, CYC_W=16, ERR_W=8). Each scenario task drives the
// observation bus cycle by cycle and compares outputs against hand-worked
// values one time unit after the sampling edge.

module tb_mips_trace_checker;
  import mips_chk_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] aluout;
  logic [31:0] readData;
  logic [31:0] writeData;
  logic        tbl_we;
  logic [4:0]  tbl_idx;
  logic [2:0]  tbl_mode;
  logic [31:0] tbl_value;
  logic        start;
  logic [15:0] max_cycles;
  logic        fail_pulse;
  logic [7:0]  err_cnt;
  logic [7:0]  unk_cnt;
  logic [31:0] first_fail_pc;
  logic [31:0] first_fail_val;
  logic        done;
  logic        pass;

  int nChecks = 0;
  int nFails  = 0;

  mips_trace_checker dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .aluout         (aluout),
    .readData       (readData),
    .writeData      (writeData),
    .tbl_we         (tbl_we),
    .tbl_idx        (tbl_idx),
    .tbl_mode       (tbl_mode),
    .tbl_value      (tbl_value),
    .start          (start),
    .max_cycles     (max_cycles),
    .fail_pulse     (fail_pulse),
    .err_cnt        (err_cnt),
    .unk_cnt        (unk_cnt),
    .first_fail_pc  (first_fail_pc),
    .first_fail_val (first_fail_val),
    .done           (done),
    .pass           (pass)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One sampling edge, then step off it so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic writeEntry(input logic [4:0] idx, input logic [2:0] mode,
                            input logic [31:0] value);
    tbl_we    = 1'b1;
    tbl_idx   = idx;
    tbl_mode  = mode;
    tbl_value = value;
    tick();
    tbl_we    = 1'b0;
  endtask

  task automatic startRun(input logic [15:0] len);
    max_cycles = len;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic runCycle(input logic [31:0] p, input logic [31:0] a,
                          input logic [31:0] w);
    pc        = p;
    aluout    = a;
    writeData = w;
    tick();
  endtask

  // Hold reset for a few edges and check every output is cleared.
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    nChecks++; if (fail_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL reset_fail_pulse got %b want 0", fail_pulse); end
    nChecks++; if (err_cnt !== 8'd0) begin nFails++; $display("[TB] FAIL reset_err_cnt got %0d want 0", err_cnt); end
    nChecks++; if (unk_cnt !== 8'd0) begin nFails++; $display("[TB] FAIL reset_unk_cnt got %0d want 0", unk_cnt); end
    nChecks++; if (first_fail_pc !== 32'd0) begin nFails++; $display("[TB] FAIL reset_first_pc got %h want 0", first_fail_pc); end
    nChecks++; if (first_fail_val !== 32'd0) begin nFails++; $display("[TB] FAIL reset_first_val got %h want 0", first_fail_val); end
    nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done got %b want 0", done); end
    nChecks++; if (pass !== 1'b0) begin nFails++; $display("[TB] FAIL reset_pass got %b want 0", pass); end
  endtask

  // addi 5, addi 12, addi 3, or 7, and 4, add 11 with all entries matching.
  task automatic test_alu_program();
    logic [31:0] expAlu [6];
    expAlu = '{32'd5, 32'd12, 32'd3, 32'd7, 32'd4, 32'd11};
    doReset();
    for (int i = 0; i < 6; i++) writeEntry(5'(i), MODE_ALU, expAlu[i]);
    startRun(16'd6);
    for (int i = 0; i < 5; i++) runCycle(32'(4 * i), expAlu[i], 32'd0);
    nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL alu_done_early got %b want 0", done); end
    runCycle(32'd20, expAlu[5], 32'd0);
    nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL alu_done got %b want 1", done); end
    nChecks++; if (pass !== 1'b1) begin nFails++; $display("[TB] FAIL alu_pass got %b want 1", pass); end
    nChecks++; if (err_cnt !== 8'd0) begin nFails++; $display("[TB] FAIL alu_err got %0d want 0", err_cnt); end
    nChecks++; if (unk_cnt !== 8'd0) begin nFails++; $display("[TB] FAIL alu_unk got %0d want 0", unk_cnt); end
  endtask

  // Entry 0 expects 6, core produces 5.
  task automatic test_alu_mismatch();
    doReset();
    writeEntry(5'd0, MODE_ALU, 32'd6);
    startRun(16'd1);
    runCycle(32'h0, 32'd5, 32'd0);
    nChecks++; if (fail_pulse !== 1'b1) begin nFails++; $display("[TB] FAIL mis_pulse got %b want 1", fail_pulse); end
    nChecks++; if (err_cnt !== 8'd1) begin nFails++; $display("[TB] FAIL mis_err got %0d want 1", err_cnt); end
    nChecks++; if (first_fail_pc !== 32'h0) begin nFails++; $display("[TB] FAIL mis_first_pc got %h want 0", first_fail_pc); end
    nChecks++; if (first_fail_val !== 32'd5) begin nFails++; $display("[TB] FAIL mis_first_val got %h want 5", first_fail_val); end
    nChecks++; if (done !== 1'b1 || pass !== 1'b0) begin nFails++; $display("[TB] FAIL mis_verdict got done=%b pass=%b want done=1 pass=0", done, pass); end
    runCycle(32'h0, 32'd5, 32'd0);
    nChecks++; if (fail_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL mis_pulse_width got %b want 0", fail_pulse); end
  endtask

  // Branch target check at 0x3C plus a forbidden fall-through at 0x40.
  task automatic test_next_forbid();
    doReset();
    writeEntry(5'h0F, MODE_NEXT, 32'h44);
    writeEntry(5'h10, MODE_FORBID, 32'h0);
    startRun(16'd2);
    runCycle(32'h3C, 32'd0, 32'd0);
    nChecks++; if (err_cnt !== 8'd0) begin nFails++; $display("[TB] FAIL next_err_armed got %0d want 0", err_cnt); end
    runCycle(32'h40, 32'd0, 32'd0);
    nChecks++; if (err_cnt !== 8'd2) begin nFails++; $display("[TB] FAIL next_err_double got %0d want 2", err_cnt); end
    nChecks++; if (fail_pulse !== 1'b1) begin nFails++; $display("[TB] FAIL next_pulse got %b want 1", fail_pulse); end
    nChecks++; if (first_fail_pc !== 32'h3C) begin nFails++; $display("[TB] FAIL next_first_pc got %h want 3c", first_fail_pc); end
    nChecks++; if (first_fail_val !== 32'h40) begin nFails++; $display("[TB] FAIL next_first_val got %h want 40", first_fail_val); end
    // Restart from DONE: NEXT armed on the final sample is dropped.
    startRun(16'd1);
    runCycle(32'h3C, 32'd0, 32'd0);
    nChecks++; if (err_cnt !== 8'd0 || pass !== 1'b1) begin nFails++; $display("[TB] FAIL next_drop got err=%0d pass=%b want err=0 pass=1", err_cnt, pass); end
    // Correct branch: 0x44 maps to an empty entry, so it is unknown.
    startRun(16'd2);
    runCycle(32'h3C, 32'd0, 32'd0);
    runCycle(32'h44, 32'd0, 32'd0);
    nChecks++; if (err_cnt !== 8'd0) begin nFails++; $display("[TB] FAIL next_taken_err got %0d want 0", err_cnt); end
    nChecks++; if (unk_cnt !== 8'd1) begin nFails++; $display("[TB] FAIL next_taken_unk got %0d want 1", unk_cnt); end
    // Forbidden PC on its own reports the PC as the observed value.
    startRun(16'd1);
    runCycle(32'h40, 32'h1234, 32'd0);
    nChecks++; if (err_cnt !== 8'd1) begin nFails++; $display("[TB] FAIL forbid_err got %0d want 1", err_cnt); end
    nChecks++; if (first_fail_val !== 32'h40) begin nFails++; $display("[TB] FAIL forbid_val got %h want 40", first_fail_val); end
  endtask

  // Address and store-data checks.
  task automatic test_store_addr();
    doReset();
    writeEntry(5'd0, MODE_ADDR, 32'h40);
    writeEntry(5'd1, MODE_STORE, 32'h1234);
    startRun(16'd2);
    runCycle(32'h0, 32'h40, 32'h0);
    runCycle(32'h4, 32'h0, 32'h1234);
    nChecks++; if (err_cnt !== 8'd0 || pass !== 1'b1) begin nFails++; $display("[TB] FAIL mem_ok got err=%0d pass=%b want err=0 pass=1", err_cnt, pass); end
    startRun(16'd2);
    runCycle(32'h0, 32'h40, 32'h0);
    runCycle(32'h4, 32'h0, 32'h1235);
    nChecks++; if (err_cnt !== 8'd1) begin nFails++; $display("[TB] FAIL store_err got %0d want 1", err_cnt); end
    nChecks++; if (first_fail_pc !== 32'h4 || first_fail_val !== 32'h1235) begin nFails++; $display("[TB] FAIL store_first got pc=%h val=%h want pc=4 val=1235", first_fail_pc, first_fail_val); end
  endtask

  // Out-of-table, misaligned and reserved-mode PCs only count as unknown.
  task automatic test_unknown();
    doReset();
    writeEntry(5'd1, 3'd6, 32'd0);
    startRun(16'd3);
    runCycle(32'h100, 32'd0, 32'd0);
    runCycle(32'h2, 32'd0, 32'd0);
    runCycle(32'h4, 32'd0, 32'd0);
    nChecks++; if (unk_cnt !== 8'd3) begin nFails++; $display("[TB] FAIL unk_cnt got %0d want 3", unk_cnt); end
    nChecks++; if (err_cnt !== 8'd0 || pass !== 1'b1) begin nFails++; $display("[TB] FAIL unk_verdict got err=%0d pass=%b want err=0 pass=1", err_cnt, pass); end
  endtask

  // max_cycles of zero still takes exactly one sample; DONE then holds.
  task automatic test_max_zero();
    doReset();
    startRun(16'd0);
    runCycle(32'h100, 32'd0, 32'd0);
    nChecks++; if (done !== 1'b1 || unk_cnt !== 8'd1) begin nFails++; $display("[TB] FAIL zero_run got done=%b unk=%0d want done=1 unk=1", done, unk_cnt); end
    runCycle(32'h100, 32'd0, 32'd0);
    nChecks++; if (unk_cnt !== 8'd1) begin nFails++; $display("[TB] FAIL zero_hold got %0d want 1", unk_cnt); end
  endtask

  // 300 mismatching cycles must stick at 255.
  task automatic test_saturation();
    doReset();
    writeEntry(5'd0, MODE_ALU, 32'd1);
    startRun(16'd300);
    runCycle(32'h0, 32'd0, 32'd0);
    runCycle(32'h0, 32'd0, 32'd0);
    nChecks++; if (err_cnt !== 8'd2) begin nFails++; $display("[TB] FAIL sat_early got %0d want 2", err_cnt); end
    for (int i = 0; i < 298; i++) runCycle(32'h0, 32'd0, 32'd0);
    nChecks++; if (err_cnt !== 8'd255) begin nFails++; $display("[TB] FAIL sat_err got %0d want 255", err_cnt); end
    nChecks++; if (done !== 1'b1 || pass !== 1'b0) begin nFails++; $display("[TB] FAIL sat_verdict got done=%b pass=%b want done=1 pass=0", done, pass); end
  endtask

  // Reset mid-run, then writes outside IDLE must be ignored.
  task automatic test_reset_midrun();
    doReset();
    writeEntry(5'd0, MODE_ALU, 32'd1);
    startRun(16'd10);
    runCycle(32'h0, 32'd0, 32'd0);
    runCycle(32'h0, 32'd0, 32'd0);
    nChecks++; if (err_cnt !== 8'd2) begin nFails++; $display("[TB] FAIL mid_err got %0d want 2", err_cnt); end
    doReset();
    nChecks++; if (err_cnt !== 8'd0 || unk_cnt !== 8'd0) begin nFails++; $display("[TB] FAIL mid_clear got err=%0d unk=%0d want 0 0", err_cnt, unk_cnt); end
    nChecks++; if (done !== 1'b0 || pass !== 1'b0 || fail_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL mid_flags got done=%b pass=%b pulse=%b want 0 0 0", done, pass, fail_pulse); end
    startRun(16'd4);
    tbl_we = 1'b1; tbl_idx = 5'd0; tbl_mode = MODE_ALU; tbl_value = 32'd1;
    for (int i = 0; i < 4; i++) runCycle(32'h0, 32'd0, 32'd0);
    nChecks++; if (unk_cnt !== 8'd4 || err_cnt !== 8'd0) begin nFails++; $display("[TB] FAIL mid_rerun got unk=%0d err=%0d want unk=4 err=0", unk_cnt, err_cnt); end
    nChecks++; if (pass !== 1'b1) begin nFails++; $display("[TB] FAIL mid_pass got %b want 1", pass); end
    tick();
    tbl_we = 1'b0;
    startRun(16'd1);
    runCycle(32'h0, 32'd0, 32'd0);
    nChecks++; if (unk_cnt !== 8'd1 || err_cnt !== 8'd0) begin nFails++; $display("[TB] FAIL done_write got unk=%0d err=%0d want unk=1 err=0", unk_cnt, err_cnt); end
  endtask

  initial begin
    reset      = 1'b0;
    pc         = '0;
    aluout     = '0;
    readData   = '0;
    writeData  = '0;
    tbl_we     = 1'b0;
    tbl_idx    = '0;
    tbl_mode   = '0;
    tbl_value  = '0;
    start      = 1'b0;
    max_cycles = '0;
    $display("[TB] starting mips_trace_checker bench");
    test_reset();
    test_alu_program();
    test_alu_mismatch();
    test_next_forbid();
    test_store_addr();
    test_unknown();
    test_max_zero();
    test_saturation();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
